// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte transmitter: FSM state encoding,
// frame geometry and the minimum legal bit period.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_START  = 3'd2,
      ST_DATA   = 3'd3,
      ST_PARITY = 3'd4,
      ST_STOP   = 3'd5
   } uart_state_t;

   localparam int UART_DATA_BITS        = 8;
   localparam int UART_BIT_IDX_W        = $clog2(UART_DATA_BITS);
   localparam int UART_CLKS_PER_BIT_MIN = 2;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, ticks on the terminal count
// and restarts from zero on the following cycle or whenever clear is high.
module uart_baud_cnt
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   // Out-of-range settings are pulled up to the shortest legal bit period.
   localparam int CPB = (CLKS_PER_BIT < UART_CLKS_PER_BIT_MIN) ? UART_CLKS_PER_BIT_MIN : CLKS_PER_BIT;
   localparam int W   = $clog2(CPB);
   localparam logic [W-1:0] TERMINAL = W'(CPB - 1);

   logic [W-1:0] cnt_q;

   // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset || clear || tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign tick = (cnt_q == TERMINAL);

endmodule

// File: rtl/uart_byte_tx.sv
// UART 8N1 transmitter pulling bytes from the serializer via empty/pull.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_byte_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_en,
   input  logic [7:0] src_byte,
   input  logic       src_empty,
   output logic       src_pull,
   output logic       txd,
   output logic       busy,
   output logic       frame_done
);

   uart_state_t                state_q, state_d;
   logic [UART_DATA_BITS-1:0]  shift_q, shift_d;
   logic [UART_BIT_IDX_W-1:0]  bit_idx_q, bit_idx_d;
   logic                       txd_d;
   logic                       bit_tick;
   logic                       baud_clear;
`ifdef UART_TX_PARITY_EN
   logic                       parity_q, parity_d;
`endif

   assign baud_clear = (state_q == ST_IDLE) || (state_q == ST_FETCH);

   uart_baud_cnt #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (baud_clear),
      .tick  (bit_tick)
   );

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_idx_d  = bit_idx_q;
      src_pull   = 1'b0;
      frame_done = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d   = parity_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (tx_en && !src_empty && !reset) begin
               src_pull = 1'b1;
               state_d  = ST_FETCH;
            end
         end
         ST_FETCH: begin
            shift_d = src_byte;
`ifdef UART_TX_PARITY_EN
            parity_d = ^src_byte;
`endif
            state_d = ST_START;
         end
         ST_START: begin
            if (bit_tick) begin
               bit_idx_d = '0;
               state_d   = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_tick) begin
               shift_d = shift_q >> 1;
               if (bit_idx_q == UART_BIT_IDX_W'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_tick) state_d = ST_STOP;
         end
`endif
         ST_STOP: begin
            if (bit_tick) begin
               frame_done = !reset;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // txd is registered, so it is derived from the state being entered.
      case (state_d)
         ST_START:  txd_d = 1'b0;
         ST_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: txd_d = parity_d;
`endif
         default:   txd_d = 1'b1;
      endcase
   end

   // NOTE: the shift register is a plain datapath register, so it takes the reset like any other flop.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_idx_q <= '0;
         txd       <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         txd       <= txd_d;
`ifdef UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   assign busy = (state_q != ST_IDLE) || src_pull;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Self-checking bench for uart_byte_tx: a serializer queue drives the DUT and
// a cycle-indexed waveform model predicts txd, src_pull, busy and frame_done.
module tb_uart_byte_tx;

   localparam int CPB   = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FB    = 11;
`else
   localparam int FB    = 10;
`endif
   localparam int L     = FB * CPB;
   localparam int DEPTH = 8192;

   logic       clk;
   logic       reset;
   logic       tx_en;
   logic [7:0] src_byte;
   logic       src_empty;
   logic       src_pull;
   logic       txd;
   logic       busy;
   logic       frame_done;

   uart_byte_tx #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .tx_en      (tx_en),
      .src_byte   (src_byte),
      .src_empty  (src_empty),
      .src_pull   (src_pull),
      .txd        (txd),
      .busy       (busy),
      .frame_done (frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model state
   logic [7:0] q[$];
   bit         exp_txd [DEPTH];
   bit         exp_fd  [DEPTH];
   int         cyc        = 0;
   int         busy_until = -1;
   bit         hold_empty = 1'b0;
   bit         pulled     = 1'b0;
   int         n_checks   = 0;
   int         n_fail     = 0;
   int         n_pull_exp = 0;
   int         n_pull_obs = 0;
   int         n_done_exp = 0;
   int         n_done_obs = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp_v, cyc);
      end
   endtask

   function automatic bit frame_bit(input logic [7:0] b, input int i);
      if (i == 0)      return 1'b0;
      if (i <= 8)      return b[i-1];
      if (i == FB - 1) return 1'b1;
      return ^b;
   endfunction

   function automatic void refresh_empty();
      src_empty = hold_empty || (q.size() == 0);
   endfunction

   task automatic push(input logic [7:0] b);
      q.push_back(b);
      refresh_empty();
   endtask

   // One clock cycle: check outputs at the falling edge, advance the model,
   // then present the serializer's response just after the rising edge.
   task automatic cycle();
      bit         exp_pull;
      bit         got_pull;
      logic [7:0] b;
      got_pull = 1'b0;
      b        = 8'h00;
      @(negedge clk);
      exp_pull = (cyc > busy_until) && tx_en && !src_empty && !reset;
      check("src_pull", src_pull, exp_pull);
      check("txd", txd, exp_txd[cyc]);
      check("busy", busy, (cyc <= busy_until) || exp_pull);
      check("frame_done", frame_done, exp_fd[cyc] && !reset);
      if (src_pull) n_pull_obs++;
      if (frame_done) n_done_obs++;
      if (exp_fd[cyc] && !reset) n_done_exp++;
      if (exp_pull) begin
         b = q.pop_front();
         got_pull = 1'b1;
         pulled = 1'b1;
         n_pull_exp++;
         for (int i = 0; i < L; i++) exp_txd[cyc + 2 + i] = frame_bit(b, i / CPB);
         exp_fd[cyc + 1 + L] = 1'b1;
         busy_until = cyc + 1 + L;
      end
      if (reset) begin
         if (busy_until > cyc) busy_until = cyc;
         for (int i = cyc + 1; i < cyc + L + 4; i++) begin
            exp_txd[i] = 1'b1;
            exp_fd[i]  = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      src_byte = got_pull ? b : 8'($urandom);
      refresh_empty();
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic wait_pull(input string tag);
      int n;
      n = 0;
      pulled = 1'b0;
      while (!pulled && n < 200) begin
         cycle();
         n++;
      end
      check(tag, pulled, 1'b1);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         exp_txd[i] = 1'b1;
         exp_fd[i]  = 1'b0;
      end
      reset    = 1'b1;
      tx_en    = 1'b0;
      src_byte = 8'h00;
      src_empty = 1'b1;

      // Reset held for three cycles: idle outputs throughout.
      run(3);
      reset = 1'b0;
      run(2);

      // Single frame of 0xA5.
      tx_en = 1'b1;
      push(8'hA5);
      run(L + 8);

      // Back-to-back frames from a three-byte serializer.
      push(8'h01);
      push(8'h80);
      push(8'hFF);
      run(3 * (L + 2) + 6);

      // tx_en dropped in the middle of 0x3C; next byte waits until re-enabled.
      push(8'h3C);
      push(8'h5A);
      wait_pull("pull_3c");
      run(12);
      tx_en = 1'b0;
      run(L + 20);
      tx_en = 1'b1;
      run(L + 8);

      // Reset during DATA bit 3 of 0x96; 0x11 follows, 0x96 is not resent.
      push(8'h96);
      push(8'h11);
      wait_pull("pull_96");
      run(1 + CPB + 3 * CPB + 1);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      run(L + 10);

`ifdef UART_TX_PARITY_EN
      // Parity frames: 0x07 carries parity 1, 0x03 carries parity 0.
      push(8'h07);
      push(8'h03);
      run(2 * (L + 2) + 6);
`endif

      // Randomized traffic: random bytes, tx_en toggling, serializer stalls, rare resets.
      for (int i = 0; i < 1500; i++) begin
         if (q.size() < 4 && $urandom_range(0, 9) == 0) push(8'($urandom));
         if ($urandom_range(0, 39) == 0) tx_en = ~tx_en;
         if ($urandom_range(0, 29) == 0) begin
            hold_empty = ~hold_empty;
            refresh_empty();
         end
         reset = ($urandom_range(0, 399) == 0);
         cycle();
      end
      reset = 1'b0;
      tx_en = 1'b1;
      hold_empty = 1'b0;
      refresh_empty();
      run(6 * (L + 2));

      check("pull_count", n_pull_obs, n_pull_exp);
      check("frame_done_count", n_done_obs, n_done_exp);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
